// File: rtl/f_chk_pkg.sv
// Shared definitions for the f response checker.
//   state_t : sweep controller states
//   VEC_W   : width of one stimulus vector {a,b,c,d}
//   NUM_VEC : number of vectors in one exhaustive sweep
//   CNT_W   : hold-counter width, sized for the largest supported hold length
package f_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VEC_W    = 4;
  localparam int NUM_VEC  = 16;
  localparam int HOLD_MAX = 65535;
  localparam int CNT_W    = $clog2(HOLD_MAX + 1);

endpackage

// File: rtl/f_hold_timer.sv
// Hold timer for the f response checker.
// Counts 0..HOLD_CYCLES-1 while clear is low, wrapping to 0 after the last
// count; expire is high during that last count.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  forces the count to 0 (and suppresses expire)
//   expire out high on the last count of the hold period
module f_hold_timer
  import f_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = !clear && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/f_response_checker.sv
// Response checker for the 4-input function f.
// Sweeps {a,b,c,d} through 0..15, holding each vector HOLD_CYCLES clocks, and
// compares dut_out (sampled just before the vector changes) against EXPECTED.
//   clk, rst_n      clock, asynchronous active-low reset
//   start           pulse that begins a sweep (ignored while busy)
//   dut_out         output of f under test (same clock domain, combinational)
//   a, b, c, d      registered stimulus, a = MSB
//   busy, done      sweep in progress / sweep finished
//   pass            done with zero mismatches
//   err_count       mismatching vectors in the last sweep
//   first_fail_vld  a mismatch has been seen this sweep
//   first_fail_vec  vector of the first mismatch
module f_response_checker
  import f_chk_pkg::*;
#(
  parameter int          HOLD_CYCLES = 20,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_fail_vld,
  output logic [3:0] first_fail_vec
);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [4:0]       err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [VEC_W-1:0] ffvec_q, ffvec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             expire;
  logic             mismatch;

  // The timer only runs during a sweep, so it restarts from 0 on every start.
  f_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != RUN),
    .expire(expire)
  );

  assign mismatch = (dut_out != EXPECTED[vec_q]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (expire) begin
          if (mismatch) begin
            err_d = err_q + 5'd1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
          if (vec_q == VEC_W'(NUM_VEC - 1)) begin
            // Last vector compared: return stimulus to zero and finish.
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // pass tracks the registered done/err values that will appear this edge.
    pass_d = done_d && (err_d == 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign {a, b, c, d}   = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;

endmodule
